// File: rtl/byte_write_coalescer.sv
// Collects byte writes into one pending RAM word and emits it as a single
// strobed word write on completion, flush, timeout or address change.
module byte_write_coalescer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 4
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_address,
    input  logic [7:0]                 in_data,
    input  logic                       in_flush,
    output logic                       wr_enable,
    output logic [ADDR_WIDTH-1:0]      wr_address,
    output logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH/8-1:0]    wr_strb,
    output logic                       busy
);
    localparam int LANES    = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(LANES);
    localparam int LSB_W    = (ADDR_LSB > 0) ? ADDR_LSB : 1;
    localparam int WORD_W   = ADDR_WIDTH - ADDR_LSB;
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : CNT_W'(1);

    logic                  pend_valid_q, pend_valid_d;
    logic [WORD_W-1:0]     pend_word_q, pend_word_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [LANES-1:0]      pend_strb_q, pend_strb_d;
    logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic                  in_ready_q;
    logic                  wr_enable_q, wr_enable_d;
    logic [ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [LANES-1:0]      wr_strb_q, wr_strb_d;

    logic [LSB_W-1:0]      in_lane;
    logic [WORD_W-1:0]     in_word, last_word;
    logic                  accept, hit, miss, haz_in, haz_pend, timeout_hit;
    logic [LANES-1:0]      merged_strb;
    logic [DATA_WIDTH-1:0] merged_data;

    generate
        if (ADDR_LSB > 0) begin : g_lane
            assign in_lane = in_address[LSB_W-1:0];
        end else begin : g_nolane
            assign in_lane = '0;
        end
    endgenerate

    assign in_word     = in_address[ADDR_WIDTH-1:ADDR_LSB];
    assign last_word   = wr_address_q[ADDR_WIDTH-1:ADDR_LSB];
    assign accept      = in_valid && in_ready_q;
    assign hit         = pend_valid_q && (in_word == pend_word_q);
    assign miss        = pend_valid_q && !hit;
    // The RAM must never see the same word on two consecutive edges.
    assign haz_in      = wr_enable_q && (in_word == last_word);
    assign haz_pend    = wr_enable_q && (pend_word_q == last_word);
    assign timeout_hit = (TIMEOUT > 0) && (idle_cnt_q == CNT_MAX);

    always_comb begin
        merged_strb = (hit ? pend_strb_q : '0) | (LANES'(1) << in_lane);
        merged_data = hit ? pend_data_q : '0;
        for (int l = 0; l < LANES; l++) begin
            if (in_lane == LSB_W'(l)) merged_data[l*8 +: 8] = in_data;
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_word_d  = pend_word_q;
        pend_data_d  = pend_data_q;
        pend_strb_d  = pend_strb_q;
        idle_cnt_d   = (pend_valid_q && idle_cnt_q != CNT_MAX) ? idle_cnt_q + 1'b1 : idle_cnt_q;
        wr_enable_d  = 1'b0;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        wr_strb_d    = wr_strb_q;

        if (accept) begin
            idle_cnt_d   = '0;
            pend_valid_d = 1'b1;
            pend_word_d  = in_word;
            pend_data_d  = merged_data;
            pend_strb_d  = merged_strb;
            if (miss) begin
                // A blocked emit leaves wr_enable low, so the held word can
                // never equal the word written at the previous edge here.
                wr_enable_d  = 1'b1;
                wr_address_d = ADDR_WIDTH'(pend_word_q) << ADDR_LSB;
                wr_data_d    = pend_data_q;
                wr_strb_d    = pend_strb_q;
            end else if ((merged_strb == '1 || in_flush) && !haz_in) begin
                wr_enable_d  = 1'b1;
                wr_address_d = ADDR_WIDTH'(in_word) << ADDR_LSB;
                wr_data_d    = merged_data;
                wr_strb_d    = merged_strb;
                pend_valid_d = 1'b0;
                pend_data_d  = '0;
                pend_strb_d  = '0;
            end
        end else if (pend_valid_q && (in_flush || timeout_hit) && !haz_pend) begin
            wr_enable_d  = 1'b1;
            wr_address_d = ADDR_WIDTH'(pend_word_q) << ADDR_LSB;
            wr_data_d    = pend_data_q;
            wr_strb_d    = pend_strb_q;
            pend_valid_d = 1'b0;
            pend_data_d  = '0;
            pend_strb_d  = '0;
            idle_cnt_d   = '0;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            pend_valid_q <= 1'b0;
            pend_word_q  <= '0;
            pend_data_q  <= '0;
            pend_strb_q  <= '0;
            idle_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            wr_enable_q  <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_word_q  <= pend_word_d;
            pend_data_q  <= pend_data_d;
            pend_strb_q  <= pend_strb_d;
            idle_cnt_q   <= idle_cnt_d;
            in_ready_q   <= 1'b1;
            wr_enable_q  <= wr_enable_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            wr_strb_q    <= wr_strb_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_enable  = wr_enable_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
    assign wr_strb    = wr_strb_q;
    assign busy       = pend_valid_q;
endmodule
